i2c_master_byte: RTL and testbench
==================================

# i2c_master_byte

Byte-level sequencer of the I2C master, directly upstream of `I2C_master_bit`. Accepts byte commands (START, STOP, WRITE, READ+ACK, READ+NACK) from the transaction controller. Expands each into a sequence of bit commands on the bit layer's go/command/finish handshake. Returns received data and the slave's acknowledge.

## Interface
- `WIDTH`, default 8: bits per data transfer; MSB sent/received first.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `go`  in  1  byte request; level, held high until `finish` is seen.
- `command`  in  3  byte command: 001 START, 010 STOP, 011 WRITE, 100 READ then ACK, 101 READ then NACK; 000/110/111 no-op.
- `data_in`  in  WIDTH  byte to transmit, sampled when the command is accepted.
- `finish`  out  1  byte command complete; high in DONE.
- `data_out`  out  WIDTH  last byte read.
- `ack_n`  out  1  acknowledge sampled after last WRITE: 0 = ACK, 1 = NACK.
- `bit_go`  out  1  to bit layer `go`.
- `bit_command`  out  3  to bit layer `command`: 010 start, 011 stop, 100 data 0, 101 data 1, 110 ACK, 111 NACK, 001 read bit.
- `bit_finish`  in  1  from bit layer `finish`.
- `bit_rx`  in  1  SDA value sampled by bit layer; valid while `bit_finish`=1 for a 001 command.

## Operation
- States: IDLE, ISSUE, RELEASE, DONE.
- IDLE: `go`=1 latches `command` and `data_in` into a shift register, clears `bit_cnt`, and moves to ISSUE.
- A no-op command goes IDLE→DONE with no bit traffic.
- ISSUE: drive `bit_go`=1 with the current `bit_command`. On `bit_finish`=1:
  - If the command is 001, shift `bit_rx` into the read shift register, or latch it into `ack_n` for the WRITE ack slot.
  - Move to RELEASE.
- RELEASE: `bit_go`=0 and `bit_command` holds its value. Wait for `bit_finish`=0. Then increment `bit_cnt`; go to ISSUE if more bits remain, else DONE.
- Bit sequences:
  - START: one 010.
  - STOP: one 011.
  - WRITE: WIDTH × (100|101 per data bit, MSB first), then one 001 whose `bit_rx` becomes `ack_n`.
  - READ: WIDTH × 001, shifting in MSB first, then 110 (cmd 100) or 111 (cmd 101).
- DONE: `finish`=1 while `go`=1. Return to IDLE the cycle `go` is seen low.
- `go` dropped mid-transaction is ignored. The byte completes, then `finish` is a single-cycle pulse.
- `data_out` updates only at completion of READ and holds otherwise. `ack_n` updates only at completion of WRITE.
- `bit_cnt` is 0..WIDTH, sized `$clog2(WIDTH+1)`, and never wraps.

## Timing
- Reset values: `finish`=0, `bit_go`=0, `bit_command`=000, `data_out`=0, `ack_n`=1, state IDLE.
- Reset asserted mid-transaction aborts at the next edge. `bit_go` drops immediately; no STOP is generated.
- `go` high in IDLE at edge n gives `bit_go`=1 from edge n+1.
- `bit_finish` high at edge m gives `bit_go`=0 from edge m+1. The minimum low time of `bit_go` between bits is 1 cycle.
- Byte latency with zero-latency bit layer:
  - START/STOP: 4 cycles from accept to `finish`.
  - WRITE/READ: 2·(WIDTH+1)+2 cycles.
- `finish` rises the cycle after the last RELEASE completes.
- `bit_command` is stable throughout ISSUE and RELEASE for a given bit.

## Structure
- Shared package `i2c_pkg`:
  - byte command codes,
  - bit command codes (shared with `I2C_master_bit`),
  - state encoding.
- Single module. An optional sub-module `i2c_byte_shift` (WIDTH-bit loadable MSB-first shift register with serial in/out) is used for both `data_in` and read data.

## Test plan
- Bench uses a behavioural bit-layer model: finish 3 cycles after `bit_go`, held until `bit_go`=0, `bit_rx` from a scripted vector.
- START then STOP → exactly one 010 then one 011 `bit_command` handshake each; `finish` after each; `data_out`=0, `ack_n`=1 unchanged.
- WRITE `data_in`=8'hA5, model returns `bit_rx`=0 on the ack slot → bit commands 101,100,101,100,100,101,100,101,001; `ack_n`=0.
- WRITE 8'h3C with `bit_rx`=1 on the ack slot → `ack_n`=1; then READ+ACK with `bit_rx` stream 1,1,0,0,1,0,1,0 → eight 001 then one 110; `data_out`=8'hCA.
- READ+NACK with all-ones stream → `data_out`=8'hFF; last bit command 111. Keep `go` high 5 cycles past `finish` → `finish` held, no new transaction.
- Drop `go` after 2 bits of a WRITE → byte still completes, 1-cycle `finish`. Assert `reset_n`=0 during bit 4 of a READ → next edge `bit_go`=0, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C master codes: byte commands, bit-layer commands and byte sequencer state encoding.
package i2c_pkg;

    localparam logic [2:0] ByteNop      = 3'b000;
    localparam logic [2:0] ByteStart    = 3'b001;
    localparam logic [2:0] ByteStop     = 3'b010;
    localparam logic [2:0] ByteWrite    = 3'b011;
    localparam logic [2:0] ByteReadAck  = 3'b100;
    localparam logic [2:0] ByteReadNack = 3'b101;

    localparam logic [2:0] BitIdle  = 3'b000;
    localparam logic [2:0] BitRead  = 3'b001;
    localparam logic [2:0] BitStart = 3'b010;
    localparam logic [2:0] BitStop  = 3'b011;
    localparam logic [2:0] BitData0 = 3'b100;
    localparam logic [2:0] BitData1 = 3'b101;
    localparam logic [2:0] BitAck   = 3'b110;
    localparam logic [2:0] BitNack  = 3'b111;

    localparam logic [1:0] StIdle    = 2'b00;
    localparam logic [1:0] StIssue   = 2'b01;
    localparam logic [1:0] StRelease = 2'b10;
    localparam logic [1:0] StDone    = 2'b11;

    function automatic logic is_byte_cmd(input logic [2:0] cmd);
        return (cmd >= ByteStart) && (cmd <= ByteReadNack);
    endfunction

endpackage

// File: rtl/i2c_byte_shift.sv
// Loadable MSB-first shift register: parallel load, shift left with serial input at the LSB.
module i2c_byte_shift #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             serial_i,
    output logic             serial_o,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_val_i;
        end else if (shift_i) begin
            sr_d = {sr_q[Width-2:0], serial_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign serial_o = sr_q[Width-1];
    assign q_o      = sr_q;

endmodule

// File: rtl/i2c_master_byte.sv
// I2C master byte sequencer: expands byte commands into bit-layer go/command/finish handshakes.
module i2c_master_byte
    import i2c_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             go,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] data_in,
    output logic             finish,
    output logic [WIDTH-1:0] data_out,
    output logic             ack_n,
    output logic             bit_go,
    output logic [2:0]       bit_command,
    input  logic             bit_finish,
    input  logic             bit_rx
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       cmd_q, cmd_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             ack_n_q, ack_n_d;

    logic             sr_load, sr_shift, sr_sin, sr_msb;
    logic [WIDTH-1:0] sr_val;
    logic             data_slot, last_bit;

    i2c_byte_shift #(
        .Width (WIDTH)
    ) u_shift (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .load_i     (sr_load),
        .load_val_i (data_in),
        .shift_i    (sr_shift),
        .serial_i   (sr_sin),
        .serial_o   (sr_msb),
        .q_o        (sr_val)
    );

    // Slot WIDTH is the acknowledge slot of WRITE/READ; START/STOP have a single bit.
    assign data_slot = (bit_cnt_q != CntW'(WIDTH));
    assign last_bit  = (cmd_q == ByteStart) || (cmd_q == ByteStop) || !data_slot;

    always_comb begin
        bit_command = BitIdle;
        if (state_q == StIssue || state_q == StRelease) begin
            unique case (cmd_q)
                ByteStart:    bit_command = BitStart;
                ByteStop:     bit_command = BitStop;
                ByteWrite:    bit_command = data_slot ? (sr_msb ? BitData1 : BitData0) : BitRead;
                ByteReadAck:  bit_command = data_slot ? BitRead : BitAck;
                ByteReadNack: bit_command = data_slot ? BitRead : BitNack;
                default:      bit_command = BitIdle;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        bit_cnt_d  = bit_cnt_q;
        data_out_d = data_out_q;
        ack_n_d    = ack_n_q;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_sin     = 1'b0;
        case (state_q)
            StIdle: begin
                if (go) begin
                    cmd_d     = command;
                    sr_load   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = is_byte_cmd(command) ? StIssue : StDone;
                end
            end
            StIssue: begin
                if (bit_finish) begin
                    state_d = StRelease;
                    if (bit_command == BitRead) begin
                        if (cmd_q == ByteWrite) begin
                            ack_n_d = bit_rx;
                        end else begin
                            sr_shift = 1'b1;
                            sr_sin   = bit_rx;
                        end
                    end
                end
            end
            StRelease: begin
                // Write data shifts only here so bit_command stays stable through RELEASE.
                if (!bit_finish) begin
                    if (last_bit) begin
                        state_d = StDone;
                        if (cmd_q == ByteReadAck || cmd_q == ByteReadNack) begin
                            data_out_d = sr_val;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        state_d   = StIssue;
                        sr_shift  = (cmd_q == ByteWrite);
                    end
                end
            end
            StDone: begin
                if (!go) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cmd_q      <= ByteNop;
            bit_cnt_q  <= '0;
            data_out_q <= '0;
            ack_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            bit_cnt_q  <= bit_cnt_d;
            data_out_q <= data_out_d;
            ack_n_q    <= ack_n_d;
        end
    end

    assign bit_go   = (state_q == StIssue);
    assign finish   = (state_q == StDone);
    assign data_out = data_out_q;
    assign ack_n    = ack_n_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Randomized bench for i2c_master_byte with a behavioural bit-layer responder and byte-level model.
module tb_i2c_master_byte;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         go = 1'b0;
    logic [2:0]   command = 3'b000;
    logic [W-1:0] data_in = '0;
    logic         finish;
    logic [W-1:0] data_out;
    logic         ack_n;
    logic         bit_go;
    logic [2:0]   bit_command;
    logic         bit_finish = 1'b0;
    logic         bit_rx = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0]   cmd_log[$];
    logic         rx_script[$];
    int           busy_cnt = 0;
    logic [W-1:0] exp_data_out = '0;
    logic         exp_ack = 1'b1;

    i2c_master_byte #(
        .WIDTH (W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .go          (go),
        .command     (command),
        .data_in     (data_in),
        .finish      (finish),
        .data_out    (data_out),
        .ack_n       (ack_n),
        .bit_go      (bit_go),
        .bit_command (bit_command),
        .bit_finish  (bit_finish),
        .bit_rx      (bit_rx)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit layer: finish on the third cycle of bit_go, held until bit_go drops.
    always @(negedge clock) begin
        if (!bit_go) begin
            bit_finish = 1'b0;
            busy_cnt   = 0;
        end else if (!bit_finish) begin
            busy_cnt++;
            if (busy_cnt == 3) begin
                bit_finish = 1'b1;
                cmd_log.push_back(bit_command);
                if (bit_command == 3'b001) begin
                    bit_rx = (rx_script.size() > 0) ? rx_script.pop_front() : 1'b1;
                end
            end
        end
    end

    task automatic run_byte(input logic [2:0] c, input logic [W-1:0] d, input logic [W-1:0] rx_data,
                            input logic rx_ack, input int hold, input int drop_after);
        logic [2:0] exp_q[$];
        int cyc;
        exp_q = {};
        rx_script.delete();
        case (c)
            3'd1: exp_q.push_back(3'b010);
            3'd2: exp_q.push_back(3'b011);
            3'd3: begin
                for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i] ? 3'b101 : 3'b100);
                exp_q.push_back(3'b001);
                rx_script.push_back(rx_ack);
                exp_ack = rx_ack;
            end
            3'd4, 3'd5: begin
                for (int i = W - 1; i >= 0; i--) begin
                    exp_q.push_back(3'b001);
                    rx_script.push_back(rx_data[i]);
                end
                exp_q.push_back(c == 3'd4 ? 3'b110 : 3'b111);
                exp_data_out = rx_data;
            end
            default: ;
        endcase
        cmd_log.delete();
        @(negedge clock);
        go = 1'b1;
        command = c;
        data_in = d;
        @(negedge clock);
        check("bit_go_latency", 32'(bit_go), 32'(exp_q.size() > 0));
        cyc = 0;
        while (!finish && cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (drop_after >= 0 && cmd_log.size() >= drop_after) go = 1'b0;
        end
        check("finish_timeout", 32'(cyc < 300), 32'd1);
        check("bit_count", 32'(cmd_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++) begin
            check($sformatf("bit_cmd[%0d]", i), 32'(cmd_log[i]), 32'(exp_q[i]));
        end
        check("data_out", 32'(data_out), 32'(exp_data_out));
        check("ack_n", 32'(ack_n), 32'(exp_ack));
        if (go) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                check("finish_held", 32'(finish), 32'd1);
                check("no_new_bit", 32'(bit_go), 32'd0);
            end
            go = 1'b0;
        end
        @(negedge clock);
        check("finish_low", 32'(finish), 32'd0);
    endtask

    initial begin
        int cyc;
        logic [2:0] rc;
        repeat (3) @(negedge clock);
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_bit_go", 32'(bit_go), 32'd0);
        check("rst_bit_cmd", 32'(bit_command), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_ack_n", 32'(ack_n), 32'd1);
        reset_n = 1'b1;

        run_byte(3'd1, 8'h00, 8'h00, 1'b1, 0, -1);
        run_byte(3'd2, 8'h00, 8'h00, 1'b1, 0, -1);
        run_byte(3'd3, 8'hA5, 8'h00, 1'b0, 0, -1);
        run_byte(3'd3, 8'h3C, 8'h00, 1'b1, 0, -1);
        run_byte(3'd4, 8'h00, 8'hCA, 1'b1, 0, -1);
        run_byte(3'd5, 8'h00, 8'hFF, 1'b1, 5, -1);
        run_byte(3'd0, 8'h12, 8'h00, 1'b1, 2, -1);
        run_byte(3'd3, 8'h96, 8'h00, 1'b0, 0, 2);

        // Reset while the fourth READ bit is being issued.
        rx_script.delete();
        rx_script.push_back(1'b1);
        rx_script.push_back(1'b0);
        rx_script.push_back(1'b1);
        cmd_log.delete();
        @(negedge clock);
        go = 1'b1;
        command = 3'd4;
        cyc = 0;
        while (!(cmd_log.size() == 3 && bit_go) && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check("reset_wait", 32'(cyc < 200), 32'd1);
        reset_n = 1'b0;
        go = 1'b0;
        @(negedge clock);
        check("abort_bit_go", 32'(bit_go), 32'd0);
        check("abort_finish", 32'(finish), 32'd0);
        check("abort_bit_cmd", 32'(bit_command), 32'd0);
        check("abort_data_out", 32'(data_out), 32'd0);
        check("abort_ack_n", 32'(ack_n), 32'd1);
        exp_data_out = '0;
        exp_ack = 1'b1;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_after_reset", 32'(bit_go | finish), 32'd0);

        for (int t = 0; t < 40; t++) begin
            rc = 3'($urandom_range(0, 7));
            run_byte(rc, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
